// File: rtl/vga_timing_pkg.sv
// VGA timing package: default 640x480@60 constants and axis phase encodings
// shared by the sync generator and downstream VGA stages.
package vga_timing_pkg;

   localparam int unsigned H_ACTIVE_D = 640;
   localparam int unsigned H_FP_D     = 16;
   localparam int unsigned H_SYNC_D   = 96;
   localparam int unsigned H_BP_D     = 48;
   localparam int unsigned V_ACTIVE_D = 480;
   localparam int unsigned V_FP_D     = 10;
   localparam int unsigned V_SYNC_D   = 2;
   localparam int unsigned V_BP_D     = 33;

   localparam int unsigned H_TOTAL_D =
      H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;
   localparam int unsigned V_TOTAL_D =
      V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;

   typedef enum logic [1:0] {
      PH_VIS   = 2'd0,
      PH_FRONT = 2'd1,
      PH_SYNC  = 2'd2,
      PH_BACK  = 2'd3
   } axis_phase_t;

   localparam axis_phase_t H_VIS    = PH_VIS;
   localparam axis_phase_t H_FRONT  = PH_FRONT;
   localparam axis_phase_t H_SYNC_S = PH_SYNC;
   localparam axis_phase_t H_BACK   = PH_BACK;
   localparam axis_phase_t V_VIS    = PH_VIS;
   localparam axis_phase_t V_FRONT  = PH_FRONT;
   localparam axis_phase_t V_SYNC_S = PH_SYNC;
   localparam axis_phase_t V_BACK   = PH_BACK;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter plus its
// visible/front/sync/back phase FSM.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int unsigned ACTIVE = 640,
   parameter int unsigned FP     = 16,
   parameter int unsigned SYNC   = 96,
   parameter int unsigned BACK   = 48
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        step,
   output logic [15:0] count,
   output axis_phase_t phase,
   output axis_phase_t phase_next,
   output logic        wrap
);

   localparam logic [15:0] LAST    = 16'(ACTIVE + FP + SYNC + BACK - 1);
   localparam logic [15:0] E_FRONT = 16'(ACTIVE);
   localparam logic [15:0] E_SYNC  = 16'(ACTIVE + FP);
   localparam logic [15:0] E_BACK  = 16'(ACTIVE + FP + SYNC);

   logic [15:0] count_next;

   assign count_next = (count == LAST) ? 16'd0 : count + 16'd1;
   assign wrap       = step && (count == LAST);

   // phase_next is the state after a step, whether or not one happens
   always_comb begin
      phase_next = phase;
      unique case (phase)
         PH_VIS:   if (count_next == E_FRONT) phase_next = PH_FRONT;
         PH_FRONT: if (count_next == E_SYNC)  phase_next = PH_SYNC;
         PH_SYNC:  if (count_next == E_BACK)  phase_next = PH_BACK;
         PH_BACK:  if (count_next == 16'd0)   phase_next = PH_VIS;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= LAST;
         phase <= PH_BACK;
      end else if (step) begin
         count <= count_next;
         phase <= phase_next;
      end
   end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: row/column counters, sync pulses, visible-window
// flag and line/frame start strobes, all advanced by a pixel tick.
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE    = H_ACTIVE_D,
   parameter int unsigned H_FP        = H_FP_D,
   parameter int unsigned H_SYNC      = H_SYNC_D,
   parameter int unsigned H_BP        = H_BP_D,
   parameter int unsigned V_ACTIVE    = V_ACTIVE_D,
   parameter int unsigned V_FP        = V_FP_D,
   parameter int unsigned V_SYNC      = V_SYNC_D,
   parameter int unsigned V_BP        = V_BP_D,
   parameter bit          SYNC_ACTIVE = 1'b0
) (
   input  logic        vga_clk,
   input  logic        reset,
   input  logic        pix_en,
   output logic [15:0] vga_row,
   output logic [15:0] vga_col,
   output logic        hsync,
   output logic        vsync,
   output logic        video_on,
   output logic        line_start,
   output logic        frame_start
);

   axis_phase_t h_phase, h_next, h_sel;
   axis_phase_t v_phase, v_next, v_sel;
   logic        h_wrap, v_wrap;

   vga_axis_counter #(
      .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BACK(H_BP)
   ) u_h (
      .clk        (vga_clk),
      .reset      (reset),
      .step       (pix_en),
      .count      (vga_col),
      .phase      (h_phase),
      .phase_next (h_next),
      .wrap       (h_wrap)
   );

   vga_axis_counter #(
      .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BACK(V_BP)
   ) u_v (
      .clk        (vga_clk),
      .reset      (reset),
      .step       (h_wrap),
      .count      (vga_row),
      .phase      (v_phase),
      .phase_next (v_next),
      .wrap       (v_wrap)
   );

   // Outputs load the phase the counters will hold after this edge
   assign h_sel = pix_en ? h_next : h_phase;
   assign v_sel = h_wrap ? v_next : v_phase;

   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         hsync       <= ~SYNC_ACTIVE;
         vsync       <= ~SYNC_ACTIVE;
         video_on    <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         hsync       <= (h_sel == H_SYNC_S) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         vsync       <= (v_sel == V_SYNC_S) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         video_on    <= (h_sel == H_VIS) && (v_sel == V_VIS);
         line_start  <= h_wrap;
         frame_start <= v_wrap;
      end
   end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default and tiny timings against a
// row/column arithmetic model, with random pixel ticks and resets.
module tb_vga_sync_gen;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic pix_en = 1'b0;
   logic pix_en_s = 1'b0;

   logic [15:0] row0, col0, row1, col1;
   logic hs0, vs0, vid0, ls0, fs0;
   logic hs1, vs1, vid1, ls1, fs1;

   always #5 clk = ~clk;

   vga_sync_gen u_dflt (
      .vga_clk(clk), .reset(reset), .pix_en(pix_en),
      .vga_row(row0), .vga_col(col0), .hsync(hs0), .vsync(vs0),
      .video_on(vid0), .line_start(ls0), .frame_start(fs0)
   );

   vga_sync_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .SYNC_ACTIVE(1'b0)
   ) u_small (
      .vga_clk(clk), .reset(reset), .pix_en(pix_en_s),
      .vga_row(row1), .vga_col(col1), .hsync(hs1), .vsync(vs1),
      .video_on(vid1), .line_start(ls1), .frame_start(fs1)
   );

   logic [63:0] got0, got1;
   assign got0 = {27'd0, row0, col0, hs0, vs0, vid0, ls0, fs0};
   assign got1 = {27'd0, row1, col1, hs1, vs1, vid1, ls1, fs1};

   int vectors = 0;
   int miscompares = 0;

   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         if (miscompares <= 40)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // model: timing constants per instance, position and advance flag
   int HA[2] = '{640, 8};
   int HF[2] = '{16, 2};
   int HS[2] = '{96, 2};
   int HB[2] = '{48, 2};
   int VA[2] = '{480, 4};
   int VF[2] = '{10, 1};
   int VS[2] = '{2, 1};
   int VB[2] = '{33, 1};
   int mcol[2];
   int mrow[2];
   bit madv[2];

   function automatic int ht(int i);
      return HA[i] + HF[i] + HS[i] + HB[i];
   endfunction

   function automatic int vt(int i);
      return VA[i] + VF[i] + VS[i] + VB[i];
   endfunction

   function automatic void m_reset(int i);
      mcol[i] = ht(i) - 1;
      mrow[i] = vt(i) - 1;
      madv[i] = 1'b0;
   endfunction

   function automatic void m_adv(int i, bit e);
      madv[i] = e;
      if (e) begin
         mcol[i] = mcol[i] + 1;
         if (mcol[i] == ht(i)) begin
            mcol[i] = 0;
            mrow[i] = (mrow[i] + 1) % vt(i);
         end
      end
   endfunction

   function automatic logic [63:0] m_exp(int i);
      int c = mcol[i];
      int r = mrow[i];
      bit h = !(c >= HA[i] + HF[i] && c < HA[i] + HF[i] + HS[i]);
      bit v = !(r >= VA[i] + VF[i] && r < VA[i] + VF[i] + VS[i]);
      bit vid = (c < HA[i]) && (r < VA[i]);
      bit ls = madv[i] && (c == 0);
      bit fs = ls && (r == 0);
      return {27'd0, 16'(r), 16'(c), h, v, vid, ls, fs};
   endfunction

   // period measurement state
   bit meas0 = 1'b0, meas1 = 1'b0;
   longint cyc = 0;
   longint last_ls0 = -1, last_fs0 = -1, last_ls1 = -1, last_fs1 = -1;
   int nfs0 = 0, nfs1 = 0;

   task automatic step(bit e0, bit e1);
      pix_en = e0;
      pix_en_s = e1;
      @(posedge clk);
      #1;
      cyc++;
      m_adv(0, e0);
      m_adv(1, e1);
      check("dflt_state", got0, m_exp(0));
      check("small_state", got1, m_exp(1));
      if (meas0 && ls0) begin
         if (last_ls0 >= 0)
            check("h_period", 64'(cyc - last_ls0), 64'd800);
         last_ls0 = cyc;
      end
      if (meas0 && fs0) begin
         nfs0++;
         if (last_fs0 >= 0)
            check("v_period", 64'(cyc - last_fs0), 64'd420000);
         last_fs0 = cyc;
      end
      if (meas1 && ls1) begin
         if (last_ls1 >= 0)
            check("small_h_period", 64'(cyc - last_ls1), 64'd14);
         last_ls1 = cyc;
      end
      if (meas1 && fs1) begin
         nfs1++;
         if (last_fs1 >= 0)
            check("small_v_period", 64'(cyc - last_fs1), 64'd98);
         last_fs1 = cyc;
      end
   endtask

   initial begin
      int guard;
      int prev_col;
      int run;
      bit prev_ls;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      m_reset(0);
      m_reset(1);
      check("rst_dflt", got0, m_exp(0));
      check("rst_small", got1, m_exp(1));
      #2 reset = 1'b0;

      // one full default frame; tiny timing measured then randomised
      meas0 = 1'b1;
      meas1 = 1'b1;
      for (int k = 0; k < 420001; k++) begin
         if (k == 295) meas1 = 1'b0;
         step(1'b1, (k < 295) ? 1'b1 : 1'($urandom_range(0, 1)));
      end
      meas0 = 1'b0;
      check("frame_pulses", 64'(nfs0), 64'd2);
      check("small_frame_pulses", 64'(nfs1), 64'd4);

      // run to row 200 col 300 then reset mid-cycle
      guard = 0;
      while (!(mcol[0] == 300 && mrow[0] == 200) && guard < 200000) begin
         step(1'b1, 1'($urandom_range(0, 1)));
         guard++;
      end
      check("reach_200_300", 64'(guard < 200000), 64'd1);
      #2 reset = 1'b1;
      #1;
      m_reset(0);
      m_reset(1);
      check("async_rst_dflt", got0, m_exp(0));
      check("async_rst_small", got1, m_exp(1));
      @(posedge clk);
      #1;
      check("rst_hold_dflt", got0, m_exp(0));
      #2 reset = 1'b0;
      step(1'b1, 1'b1);
      check("first_fs", 64'(fs0), 64'd1);

      // half-rate pixel tick: every count must hold for two cycles
      prev_col = -1;
      run = 0;
      prev_ls = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         step((k % 2) == 1, 1'($urandom_range(0, 1)));
         if (int'(col0) == prev_col) begin
            run++;
         end else begin
            if (prev_col >= 0 && k > 2)
               check("persist", 64'(run), 64'd2);
            prev_col = int'(col0);
            run = 1;
         end
         if (prev_ls)
            check("ls_width", 64'(ls0), 64'd0);
         prev_ls = ls0;
      end

      // random pixel ticks on both timings
      for (int k = 0; k < 5000; k++)
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
